// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC register, IF/ID pipeline register and
// a WARMUP/RUN/HALT controller. Misaligned redirects halt fetch until reset.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count and stall_count.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count,
`endif
   output logic        halted
);

   typedef enum logic [1:0] {StWarmup, StRun, StHalt} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pp4_q, pp4_d;
   logic        valid_q, valid_d;
   logic        fetch_en;   // this edge loads a real instruction
   logic        stall_en;   // this edge is a RUN stall (no redirect)
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;   // wraps modulo 2^32

   // Next-state and IF/ID next-value selection; default is hold.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pp4_d    = pp4_q;
      valid_d  = valid_q;
      fetch_en = 1'b0;
      stall_en = 1'b0;
      unique case (state_q)
         StWarmup: begin
            instr_d = NOP_INSTR;
            pp4_d   = 32'd0;
            valid_d = 1'b0;
            state_d = StRun;
         end
         StRun: begin
            if (branch_taken) begin
               instr_d = NOP_INSTR;
               pp4_d   = 32'd0;
               valid_d = 1'b0;
               if (branch_target[1:0] == 2'b00) begin
                  pc_d = branch_target;
               end else begin
                  state_d = StHalt;
               end
            end else if (stall) begin
               stall_en = 1'b1;
            end else if (flush) begin
               instr_d = NOP_INSTR;
               pp4_d   = 32'd0;
               valid_d = 1'b0;
               pc_d    = pc_plus4;
            end else begin
               instr_d  = imem_rdata;
               pp4_d    = pc_plus4;
               valid_d  = 1'b1;
               pc_d     = pc_plus4;
               fetch_en = 1'b1;
            end
         end
         StHalt: begin
            instr_d = NOP_INSTR;
            pp4_d   = 32'd0;
            valid_d = 1'b0;
         end
         default: begin
            state_d = StHalt;
         end
      endcase
   end

   // State, PC and IF/ID registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StWarmup;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pp4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pp4_q   <= pp4_d;
         valid_q <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   // Performance counters; both wrap naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (fetch_en) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall_en) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   logic unused_en;
   assign unused_en = fetch_en ^ stall_en;
`endif

   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign ifid_instr    = instr_q;
   assign ifid_pc_plus4 = pp4_q;
   assign ifid_valid    = valid_q;
   assign halted        = (state_q == StHalt);

endmodule
